dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl_if.sv | 20 ++
 rtl/dds_sweep_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// Host-side and DDS-side register write buses of the sweep controller.
// The controller takes the slave view; the host/bench takes the master view.
interface dds_sweep_ctrl_if;
  logic        m_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_wrdata;
  logic        d_wr;
  logic [7:0]  d_addr;
  logic [15:0] d_wrdata;

  modport master (
    output m_wr, m_addr, m_wrdata,
    input  d_wr, d_addr, d_wrdata
  );

  modport slave (
    input  m_wr, m_addr, m_wrdata,
    output d_wr, d_addr, d_wrdata
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep sequencer with host pass-through onto the DDS bus.
// Optional macro DDS_SWEEP_LOOP_EN: Ctrl bit2 makes the sweep repeat.
module dds_sweep_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  dds_sweep_ctrl_if.slave bus,
  output logic            sweep_busy,
  output logic            point_flag,
  output logic            sweep_done,
  output logic [15:0]     point_idx,
  output logic            host_drop
);

  localparam logic [7:0]  A_FH      = 8'd7;
  localparam logic [7:0]  A_FL      = 8'd8;
  localparam logic [7:0]  A_START_L = 8'd13;
  localparam logic [7:0]  A_START_H = 8'd14;
  localparam logic [7:0]  A_STEP_L  = 8'd15;
  localparam logic [7:0]  A_STEP_H  = 8'd16;
  localparam logic [7:0]  A_POINTS  = 8'd17;
  localparam logic [7:0]  A_DWELL   = 8'd18;
  localparam logic [7:0]  A_CTRL    = 8'd19;
  localparam logic [31:0] START_RST = 32'h0083_12B0;

  typedef enum logic [2:0] {
    IDLE, WR_H, WR_L, DWELL, NEXT
  } state_t;

  state_t state, state_nx;

  logic [31:0] start_r, step_r;
  logic [15:0] points_r, dwell_r;
  logic [31:0] sh_start, sh_step, fword;
  logic [15:0] sh_last, sh_dwell, dwell_cnt;

  logic        pend_v;
  logic [7:0]  pend_addr;
  logic [15:0] pend_data;

  logic ctrl_wr, start_req, abort_req, start_acc;
  logic dds_hit, fhl_hit, fwd, drop78;
  logic busy, drv, last_pt, dwell_end, loop_on;

  always_comb begin
    ctrl_wr   = bus.m_wr && (bus.m_addr == A_CTRL);
    abort_req = ctrl_wr && bus.m_wrdata[1];
    start_req = ctrl_wr && bus.m_wrdata[0]
                && !bus.m_wrdata[1];
    busy      = (state != IDLE);
    start_acc = start_req && !busy;
    dds_hit   = bus.m_wr && (bus.m_addr >= 8'd6)
                && (bus.m_addr <= 8'd12);
    fhl_hit   = (bus.m_addr == A_FH)
                || (bus.m_addr == A_FL);
    fwd       = dds_hit && !(busy && fhl_hit);
    drop78    = dds_hit && busy && fhl_hit;
    drv       = (state == WR_H) || (state == WR_L);
    last_pt   = (point_idx >= sh_last);
    dwell_end = (dwell_cnt == sh_dwell);
  end

  assign sweep_busy = busy;

`ifdef DDS_SWEEP_LOOP_EN
  logic loop_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      loop_r <= 1'b0;
    else if (ctrl_wr)
      loop_r <= bus.m_wrdata[2];
  end

  assign loop_on = loop_r;
`else
  assign loop_on = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Abort wins over every sweep transition.
  always_comb begin
    state_nx = state;
    if (busy && abort_req) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start_req) state_nx = WR_H;
        WR_H:  state_nx = WR_L;
        WR_L:  state_nx = DWELL;
        DWELL: if (dwell_end) state_nx = NEXT;
        NEXT:  state_nx = (!last_pt || loop_on)
                          ? WR_H : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r  <= START_RST;
      step_r   <= '0;
      points_r <= 16'd1;
      dwell_r  <= '0;
    end else if (bus.m_wr) begin
      case (bus.m_addr)
        A_START_L: start_r[15:0]  <= bus.m_wrdata;
        A_START_H: start_r[31:16] <= bus.m_wrdata;
        A_STEP_L:  step_r[15:0]   <= bus.m_wrdata;
        A_STEP_H:  step_r[31:16]  <= bus.m_wrdata;
        A_POINTS:  points_r       <= bus.m_wrdata;
        A_DWELL:   dwell_r        <= bus.m_wrdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_start   <= START_RST;
      sh_step    <= '0;
      sh_last    <= '0;
      sh_dwell   <= '0;
      fword      <= START_RST;
      point_idx  <= '0;
      dwell_cnt  <= '0;
      point_flag <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      point_flag <= (state == WR_L);
      sweep_done <= (state == NEXT) && last_pt
                    && !abort_req;
      dwell_cnt  <= (state == DWELL)
                    ? dwell_cnt + 16'd1 : '0;
      if (start_acc) begin
        sh_start  <= start_r;
        sh_step   <= step_r;
        sh_dwell  <= dwell_r;
        sh_last   <= (points_r == 16'd0)
                     ? 16'd0 : points_r - 16'd1;
        fword     <= start_r;
        point_idx <= '0;
      end else if ((state == NEXT) && !abort_req) begin
        if (!last_pt) begin
          fword     <= fword + sh_step;
          point_idx <= point_idx + 16'd1;
        end else if (loop_on) begin
          fword     <= sh_start;
          point_idx <= '0;
        end
      end
    end
  end

  // DDS bus: sweep first, then the parked host write, then a fresh one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.d_wr     <= 1'b0;
      bus.d_addr   <= '0;
      bus.d_wrdata <= '0;
      pend_v       <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
      host_drop    <= 1'b0;
    end else begin
      bus.d_wr  <= 1'b0;
      host_drop <= drop78;
      if (drv) begin
        bus.d_wr     <= 1'b1;
        bus.d_addr   <= (state == WR_H) ? A_FH : A_FL;
        bus.d_wrdata <= (state == WR_H)
                        ? fword[31:16] : fword[15:0];
        if (fwd && pend_v) begin
          host_drop <= 1'b1;
        end else if (fwd) begin
          pend_v    <= 1'b1;
          pend_addr <= bus.m_addr;
          pend_data <= bus.m_wrdata;
        end
      end else if (pend_v) begin
        bus.d_wr     <= 1'b1;
        bus.d_addr   <= pend_addr;
        bus.d_wrdata <= pend_data;
        pend_v       <= fwd;
        if (fwd) begin
          pend_addr <= bus.m_addr;
          pend_data <= bus.m_wrdata;
        end
      end else if (fwd) begin
        bus.d_wr     <= 1'b1;
        bus.d_addr   <= bus.m_addr;
        bus.d_wrdata <= bus.m_wrdata;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: timeline reference model,
// directed sweep scenarios and randomized host traffic.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sweep_busy, point_flag, sweep_done, host_drop;
  logic [15:0] point_idx;

  dds_sweep_ctrl_if bus_if();

  dds_sweep_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .sweep_busy (sweep_busy),
    .point_flag (point_flag),
    .sweep_done (sweep_done),
    .point_idx  (point_idx),
    .host_drop  (host_drop)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: a sweep is a timeline of points, each P=dwell+4
  // cycles long; offset 0 issues the high word, offset 1 the low word.
  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [31:0] m_start, m_step;
  logic [15:0] m_points, m_dwell;
  bit          m_loop;
  bit          act;
  int          k, s_n, s_p;
  logic [31:0] s_start, s_step;
  wr_t         pq[$];

  logic        e_wr, e_busy, e_flag, e_done, e_drop;
  logic [7:0]  e_addr;
  logic [15:0] e_data, e_idx;

  always @(posedge clk or negedge rst_n) begin : mdl
    bit          w, abort, start, drv, fwd, fin;
    logic [7:0]  a;
    logic [15:0] d;
    logic [31:0] word;
    int          off, p;
    wr_t         q[$];
    wr_t         tmp;
    if (!rst_n) begin
      m_start = 32'h0083_12B0;
      m_step = '0;
      m_points = 16'd1;
      m_dwell = '0;
      m_loop = 0;
      act = 0;
      k = 0;
      s_n = 1;
      s_p = 4;
      pq.delete();
      e_wr = 0; e_busy = 0; e_flag = 0;
      e_done = 0; e_drop = 0;
      e_addr = '0; e_data = '0; e_idx = '0;
    end else begin
      w = bus_if.m_wr;
      a = bus_if.m_addr;
      d = bus_if.m_wrdata;
      abort = w && a == 8'd19 && d[1];
      start = w && a == 8'd19 && d[0] && !d[1];
      off = act ? k % s_p : 0;
      p = act ? (k / s_p) % s_n : 0;
      drv = act && off < 2;
      e_wr = 0; e_flag = 0; e_done = 0;
      if (drv) begin
        word = s_start + s_step * 32'(p);
        e_wr = 1;
        e_addr = (off == 0) ? 8'd7 : 8'd8;
        e_data = (off == 0) ? word[31:16] : word[15:0];
        e_flag = (off == 1);
      end
      fwd = w && a >= 8'd6 && a <= 8'd12
            && !(act && (a == 8'd7 || a == 8'd8));
      e_drop = w && act && (a == 8'd7 || a == 8'd8);
      q = pq;
      if (fwd) begin
        tmp.a = a;
        tmp.d = d;
        q.push_back(tmp);
      end
      if (!drv && q.size() > 0) begin
        tmp = q.pop_front();
        e_wr = 1;
        e_addr = tmp.a;
        e_data = tmp.d;
      end
      if (q.size() > 1) begin
        void'(q.pop_back());
        e_drop = 1;
      end
      pq = q;
      fin = act && off == s_p - 1 && p == s_n - 1;
      if (act && abort) begin
        act = 0;
      end else if (act) begin
        if (fin) e_done = 1;
        if (fin && !m_loop) begin
          act = 0;
        end else begin
          k++;
          e_idx = 16'((k / s_p) % s_n);
        end
      end else if (start) begin
        act = 1;
        k = 0;
        s_n = (m_points == 16'd0) ? 1 : int'(m_points);
        s_p = int'(m_dwell) + 4;
        s_start = m_start;
        s_step = m_step;
        e_idx = '0;
      end
      if (w) begin
        case (a)
          8'd13: m_start[15:0] = d;
          8'd14: m_start[31:16] = d;
          8'd15: m_step[15:0] = d;
          8'd16: m_step[31:16] = d;
          8'd17: m_points = d;
          8'd18: m_dwell = d;
`ifdef DDS_SWEEP_LOOP_EN
          8'd19: m_loop = d[2];
`endif
          default: ;
        endcase
      end
      e_busy = act;
    end
  end

  typedef struct {
    int          c;
    logic [7:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t wlog[$];
  int   flag_n, done_n, drop_n;

  always @(negedge clk) begin
    ent_t en;
    if (rst_n) begin
      chk("d_wr", 32'(bus_if.d_wr), 32'(e_wr));
      if (e_wr) begin
        chk("d_addr", 32'(bus_if.d_addr), 32'(e_addr));
        chk("d_wrdata", 32'(bus_if.d_wrdata), 32'(e_data));
      end
      chk("sweep_busy", 32'(sweep_busy), 32'(e_busy));
      chk("point_flag", 32'(point_flag), 32'(e_flag));
      chk("sweep_done", 32'(sweep_done), 32'(e_done));
      chk("point_idx", 32'(point_idx), 32'(e_idx));
      chk("host_drop", 32'(host_drop), 32'(e_drop));
      if (bus_if.d_wr === 1'b1) begin
        en.c = cyc;
        en.a = bus_if.d_addr;
        en.d = bus_if.d_wrdata;
        wlog.push_back(en);
      end
      if (point_flag === 1'b1) flag_n++;
      if (sweep_done === 1'b1) done_n++;
      if (host_drop === 1'b1) drop_n++;
    end
  end

  task automatic hw(input logic [7:0] a, input logic [15:0] d);
    bus_if.m_wr = 1'b1;
    bus_if.m_addr = a;
    bus_if.m_wrdata = d;
    @(posedge clk);
    #1;
    bus_if.m_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] st, input logic [31:0] sp,
                     input logic [15:0] pts, input logic [15:0] dw);
    hw(8'd13, st[15:0]);
    hw(8'd14, st[31:16]);
    hw(8'd15, sp[15:0]);
    hw(8'd16, sp[31:16]);
    hw(8'd17, pts);
    hw(8'd18, dw);
  endtask

  task automatic clr();
    wlog.delete();
    flag_n = 0;
    done_n = 0;
    drop_n = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (sweep_busy === 1'b1 && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    vecs++;
    if (sweep_busy !== 1'b0) begin
      errs++;
      $display("FAIL wait_idle: busy=%b after %0d cycles",
               sweep_busy, n);
    end
    idle(3);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_d_wr"}, 32'(bus_if.d_wr), 0);
    chk({tag, "_d_addr"}, 32'(bus_if.d_addr), 0);
    chk({tag, "_d_wrdata"}, 32'(bus_if.d_wrdata), 0);
    chk({tag, "_busy"}, 32'(sweep_busy), 0);
    chk({tag, "_flag"}, 32'(point_flag), 0);
    chk({tag, "_done"}, 32'(sweep_done), 0);
    chk({tag, "_idx"}, 32'(point_idx), 0);
    chk({tag, "_drop"}, 32'(host_drop), 0);
  endtask

  logic [7:0]  ea[6];
  logic [15:0] ed[6];

  initial begin
    int nb, r, s;
    logic [7:0]  a;
    logic [15:0] d;
    bus_if.m_wr = 1'b0;
    bus_if.m_addr = '0;
    bus_if.m_wrdata = '0;
    clr();
    #2 rst_n = 1'b0;
    #10;
    chk_reset_vals("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Three-point sweep, dwell 4.
    cfg(32'h0001_0000, 32'h0000_0100, 16'd3, 16'd4);
    clr();
    hw(8'd19, 16'h0001);
    wait_idle(200);
    ea = '{8'd7, 8'd8, 8'd7, 8'd8, 8'd7, 8'd8};
    ed = '{16'h0001, 16'h0000, 16'h0001,
           16'h0100, 16'h0001, 16'h0200};
    chk("sw3_nwr", wlog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wlog.size()) begin
        chk("sw3_addr", 32'(wlog[i].a), 32'(ea[i]));
        chk("sw3_data", 32'(wlog[i].d), 32'(ed[i]));
      end
    end
    if (wlog.size() == 6) begin
      chk("sw3_gap0", wlog[2].c - wlog[1].c, 7);
      chk("sw3_gap1", wlog[4].c - wlog[3].c, 7);
    end
    chk("sw3_flags", flag_n, 3);
    chk("sw3_done", done_n, 1);
    chk("sw3_idx", 32'(point_idx), 2);

    // Frequency word wrap.
    cfg(32'hFFFF_FF00, 32'h0000_0200, 16'd2, 16'd0);
    clr();
    hw(8'd19, 16'h0001);
    wait_idle(100);
    chk("wrap_nwr", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("wrap_h0", 32'(wlog[0].d), 32'h0000_FFFF);
      chk("wrap_l0", 32'(wlog[1].d), 32'h0000_FF00);
      chk("wrap_h1", 32'(wlog[2].d), 32'h0000_0000);
      chk("wrap_l1", 32'(wlog[3].d), 32'h0000_0100);
    end

    // Host write to 9 during WR_H is parked behind the L write.
    cfg(32'h0002_0003, 32'h0000_0010, 16'd2, 16'd3);
    clr();
    hw(8'd19, 16'h0001);
    hw(8'd9, 16'h0123);
    wait_idle(100);
    chk("park_nwr", wlog.size(), 5);
    if (wlog.size() == 5) begin
      chk("park_prev", 32'(wlog[1].a), 8);
      chk("park_addr", 32'(wlog[2].a), 9);
      chk("park_data", 32'(wlog[2].d), 32'h0123);
    end
    chk("park_drop", drop_n, 0);

    // Host write to 8 while busy is dropped.
    cfg(32'h0005_0000, 32'h0000_0001, 16'd2, 16'd2);
    clr();
    hw(8'd19, 16'h0001);
    idle(2);
    hw(8'd8, 16'hBEEF);
    wait_idle(100);
    nb = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i].d == 16'hBEEF) nb++;
    chk("drop8_cnt", drop_n, 1);
    chk("drop8_leak", nb, 0);
    chk("drop8_nwr", wlog.size(), 4);

    // Abort in the dwell of point 1.
    cfg(32'h0010_0000, 32'h0000_0020, 16'd5, 16'd6);
    clr();
    hw(8'd19, 16'h0001);
    idle(14);
    hw(8'd19, 16'h0002);
    chk("abort_busy", 32'(sweep_busy), 0);
    chk("abort_idx", 32'(point_idx), 1);
    idle(12);
    chk("abort_done", done_n, 0);
    chk("abort_nwr", wlog.size(), 4);
    chk("abort_idx2", 32'(point_idx), 1);

    // Start and abort together is only an abort.
    clr();
    hw(8'd19, 16'h0003);
    idle(4);
    chk("sa_busy", 32'(sweep_busy), 0);
    chk("sa_nwr", wlog.size(), 0);

    // Idle pass-through, including addresses 7/8.
    clr();
    hw(8'd7, 16'h1357);
    hw(8'd12, 16'h2468);
    hw(8'd5, 16'h9999);
    idle(3);
    chk("pt_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("pt_a0", 32'(wlog[0].a), 7);
      chk("pt_d1", 32'(wlog[1].d), 32'h2468);
    end

`ifdef DDS_SWEEP_LOOP_EN
    cfg(32'h0000_0010, 32'h0000_0010, 16'd2, 16'd1);
    clr();
    hw(8'd19, 16'h0005);
    idle(40);
    chk("loop_busy", 32'(sweep_busy), 1);
    chk("loop_done", 32'(done_n >= 3), 1);
    if (wlog.size() >= 6) begin
      chk("loop_l0", 32'(wlog[1].d), 32'h0010);
      chk("loop_l1", 32'(wlog[3].d), 32'h0020);
      chk("loop_l2", 32'(wlog[5].d), 32'h0010);
    end
    hw(8'd19, 16'h0002);
    wait_idle(20);
    hw(8'd19, 16'h0000);
`endif

    // Reset in mid sweep.
    cfg(32'h0003_0000, 32'h0000_0001, 16'd4, 16'd3);
    hw(8'd19, 16'h0001);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    clr();
    idle(6);
    chk("mid_nwr", wlog.size(), 0);
    chk("mid_busy", 32'(sweep_busy), 0);

    // Randomized host traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        idle(1);
      end else begin
        s = $urandom_range(0, 99);
        d = 16'($urandom);
        if (s < 40) begin
          a = 8'($urandom_range(6, 12));
        end else if (s < 70) begin
          a = 8'($urandom_range(13, 18));
          if (a == 8'd17) d = 16'($urandom_range(0, 4));
          if (a == 8'd18) d = 16'($urandom_range(0, 5));
        end else if (s < 80) begin
          a = 8'd19;
          r = $urandom_range(0, 99);
          if (r < 70) d = 16'h0001;
          else if (r < 85) d = 16'h0002;
          else d = 16'($urandom_range(0, 7));
        end else if (s < 90) begin
          a = 8'($urandom_range(0, 5));
        end else begin
          a = 8'($urandom_range(20, 255));
        end
        hw(a, d);
      end
    end
    hw(8'd19, 16'h0002);
    wait_idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
